// File: rtl/dmem_wb_pkg.sv
// dmem_wb_pkg: shared types and constants for the MEM/WB data-memory controller
package dmem_wb_pkg;
  localparam int DMEM_AWIDTH = 32;
  localparam int DMEM_RWIDTH = 5;
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;
  typedef enum logic [1:0] {OP_ALU = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_NOP = 2'd3} op_kind_t;
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, WB = 2'd2} st_t;
endpackage

// File: rtl/dmem_wb_ctrl_if.sv
// dmem_wb_ctrl_if: op, data-memory and write-back signals of the MEM/WB controller
interface dmem_wb_ctrl_if
  import dmem_wb_pkg::*;
#(
  parameter int AWIDTH = DMEM_AWIDTH,
  parameter int RWIDTH = DMEM_RWIDTH
);
  logic op_valid;
  logic op_ready;
  op_kind_t op_kind;
  logic [AWIDTH-1:0] op_addr;
  logic [AWIDTH-1:0] op_wdata;
  logic [RWIDTH-1:0] op_rd;
  logic mem_req;
  logic mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [AWIDTH-1:0] mem_wdata;
  logic [AWIDTH-1:0] mem_rdata;
  logic mem_ready;
  logic MS2;
  logic [AWIDTH-1:0] WD;
  logic wb_valid;
  logic [RWIDTH-1:0] wb_rd;
  logic mem_err;
  modport master (
    input op_valid, op_kind, op_addr, op_wdata, op_rd, mem_rdata, mem_ready,
    output op_ready, mem_req, mem_we, mem_addr, mem_wdata, MS2, WD, wb_valid, wb_rd, mem_err
  );
  modport slave (
    output op_valid, op_kind, op_addr, op_wdata, op_rd, mem_rdata, mem_ready,
    input op_ready, mem_req, mem_we, mem_addr, mem_wdata, MS2, WD, wb_valid, wb_rd, mem_err
  );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: counts memory wait cycles and flags when the abort limit is reached
module dmem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dmem_wb_ctrl.sv
// dmem_wb_ctrl: MEM/WB data-memory sequencer and write-back select (DMEM_TIMEOUT_EN adds wait abort)
module dmem_wb_ctrl
  import dmem_wb_pkg::*;
#(
`ifdef DMEM_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 16,
`endif
  parameter int AWIDTH = DMEM_AWIDTH,
  parameter int RWIDTH = DMEM_RWIDTH
) (
  input logic clk,
  input logic rst,
  dmem_wb_ctrl_if.master bus
);
  st_t st;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] rdata_q;
  logic [RWIDTH-1:0] rd_q;
  logic accept;
  logic is_mem;
  logic expired;
  assign bus.op_ready = (st == IDLE) || (st == WB);
  assign accept = bus.op_valid && bus.op_ready;
  assign is_mem = (bus.op_kind == OP_LOAD) || (bus.op_kind == OP_STORE);
  assign bus.WD = bus.MS2 ? rdata_q : addr_q;
`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(accept && is_mem),
    .enable(st == MEM_WAIT && !bus.mem_ready),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  // addr_q/rdata_q only change on the edge that enters WB, so WD holds between write-backs
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      addr_q <= '0;
      rdata_q <= '0;
      rd_q <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.MS2 <= WB_SEL_ALU;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.mem_err <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.mem_err <= 1'b0;
      case (st)
        IDLE, WB: begin
          st <= IDLE;
          if (accept && bus.op_kind == OP_ALU) begin
            addr_q <= bus.op_addr;
            bus.wb_rd <= bus.op_rd;
            bus.MS2 <= WB_SEL_ALU;
            bus.wb_valid <= 1'b1;
            st <= WB;
          end else if (accept && is_mem) begin
            bus.mem_req <= 1'b1;
            bus.mem_we <= bus.op_kind == OP_STORE;
            bus.mem_addr <= bus.op_addr;
            bus.mem_wdata <= bus.op_kind == OP_STORE ? bus.op_wdata : bus.mem_wdata;
            rd_q <= bus.op_rd;
            st <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            st <= bus.mem_we ? IDLE : WB;
            if (!bus.mem_we) begin
              rdata_q <= bus.mem_rdata;
              bus.wb_rd <= rd_q;
              bus.MS2 <= WB_SEL_MEM;
              bus.wb_valid <= 1'b1;
            end
          end else if (expired) begin
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_err <= 1'b1;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_wb_ctrl.sv
// tb_dmem_wb_ctrl: directed self-checking bench for dmem_wb_ctrl (DMEM_TIMEOUT_EN runs the abort cases)
module tb_dmem_wb_ctrl;
  import dmem_wb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dmem_wb_ctrl_if #(.AWIDTH(32), .RWIDTH(5)) bus ();
`ifdef DMEM_TIMEOUT_EN
  dmem_wb_ctrl #(.TIMEOUT_CYCLES(4), .AWIDTH(32), .RWIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`else
  dmem_wb_ctrl #(.AWIDTH(32), .RWIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put_op(input op_kind_t k, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    bus.op_valid = 1'b1;
    bus.op_kind = k;
    bus.op_addr = a;
    bus.op_wdata = d;
    bus.op_rd = r;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({bus.op_ready, bus.mem_req, bus.mem_we, bus.MS2, bus.wb_valid, bus.mem_err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=100000", {bus.op_ready, bus.mem_req, bus.mem_we, bus.MS2, bus.wb_valid, bus.mem_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.WD, bus.wb_rd} !== 101'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.mem_addr, bus.mem_wdata, bus.WD, bus.wb_rd);
    end
  endtask
  task automatic test_alu();
    put_op(OP_ALU, 32'hFFFF_FFFF, 32'h0, 5'd3);
    tick();
    bus.op_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.MS2, bus.wb_rd, bus.WD} !== {1'b1, 1'b0, 5'd3, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL alu_wb got=v%b s%b rd%0d wd%h exp=v1 s0 rd3 wdffffffff", bus.wb_valid, bus.MS2, bus.wb_rd, bus.WD);
    end
    tick();
    total++;
    if ({bus.wb_valid, bus.op_ready, bus.WD} !== {1'b0, 1'b1, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL alu_after got=v%b rdy%b wd%h exp=v0 rdy1 wdffffffff", bus.wb_valid, bus.op_ready, bus.WD);
    end
  endtask
  task automatic test_load();
    put_op(OP_LOAD, 32'h0000_0040, 32'h0, 5'd7);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.mem_req, bus.mem_we, bus.op_ready, bus.wb_valid, bus.mem_addr} !== {4'b1000, 32'h40}) begin
        bad++;
        $display("FAIL load_wait%0d got=req%b we%b rdy%b v%b a%h exp=req1 we0 rdy0 v0 a40", i, bus.mem_req, bus.mem_we, bus.op_ready, bus.wb_valid, bus.mem_addr);
      end
      if (i == 0) begin
        total++;
        if (bus.WD !== 32'hFFFF_FFFF) begin
          bad++;
          $display("FAIL wd_hold got=%h exp=ffffffff", bus.WD);
        end
      end
      if (i == 2) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h52D5_337B;
      end
      tick();
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    total++;
    if ({bus.wb_valid, bus.MS2, bus.mem_req, bus.wb_rd, bus.WD} !== {3'b110, 5'd7, 32'h52D5_337B}) begin
      bad++;
      $display("FAIL load_wb got=v%b s%b req%b rd%0d wd%h exp=v1 s1 req0 rd7 wd52d5337b", bus.wb_valid, bus.MS2, bus.mem_req, bus.wb_rd, bus.WD);
    end
    tick();
  endtask
  task automatic test_store();
    put_op(OP_STORE, 32'h10, 32'hAAAA_5555, 5'd9);
    tick();
    bus.op_valid = 1'b0;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h10, 32'hAAAA_5555}) begin
      bad++;
      $display("FAIL store_req got=req%b we%b a%h d%h exp=req1 we1 a10 daaaa5555", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.wb_valid, bus.op_ready, bus.MS2, bus.WD} !== {5'b00011, 32'h52D5_337B}) begin
      bad++;
      $display("FAIL store_done got=req%b we%b v%b rdy%b s%b wd%h exp=req0 we0 v0 rdy1 s1 wd52d5337b", bus.mem_req, bus.mem_we, bus.wb_valid, bus.op_ready, bus.MS2, bus.WD);
    end
    tick();
    total++;
    if (bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL store_nowb got=%b exp=0", bus.wb_valid);
    end
  endtask
  task automatic test_back_to_back();
    put_op(OP_LOAD, 32'h80, 32'h0, 5'd4);
    tick();
    bus.op_valid = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.MS2, bus.op_ready, bus.wb_rd, bus.WD} !== {3'b111, 5'd4, 32'h0BAD_F00D}) begin
      bad++;
      $display("FAIL b2b_load got=v%b s%b rdy%b rd%0d wd%h exp=v1 s1 rdy1 rd4 wd0badf00d", bus.wb_valid, bus.MS2, bus.op_ready, bus.wb_rd, bus.WD);
    end
    put_op(OP_ALU, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    bus.op_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.MS2, bus.wb_rd, bus.WD} !== {2'b10, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL b2b_alu got=v%b s%b rd%0d wd%h exp=v1 s0 rd5 wd00001234", bus.wb_valid, bus.MS2, bus.wb_rd, bus.WD);
    end
    tick();
    total++;
    if (bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b exp=0", bus.wb_valid);
    end
  endtask
  task automatic test_nop_rd0();
    put_op(OP_NOP, 32'h77, 32'h0, 5'd2);
    tick();
    bus.op_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.mem_req, bus.op_ready, bus.WD} !== {3'b001, 32'h1234}) begin
      bad++;
      $display("FAIL nop got=v%b req%b rdy%b wd%h exp=v0 req0 rdy1 wd00001234", bus.wb_valid, bus.mem_req, bus.op_ready, bus.WD);
    end
    put_op(OP_ALU, 32'h55, 32'h0, 5'd0);
    tick();
    bus.op_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.WD} !== {1'b1, 5'd0, 32'h55}) begin
      bad++;
      $display("FAIL rd0 got=v%b rd%0d wd%h exp=v1 rd0 wd00000055", bus.wb_valid, bus.wb_rd, bus.WD);
    end
    tick();
  endtask
  task automatic test_rst_mid();
    put_op(OP_LOAD, 32'h200, 32'h0, 5'd8);
    tick();
    bus.op_valid = 1'b0;
    tick();
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got=%b exp=1", bus.mem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.op_ready, bus.mem_req, bus.mem_we, bus.MS2, bus.wb_valid, bus.mem_err, bus.mem_addr, bus.WD, bus.wb_rd} !== {6'b100000, 69'd0}) begin
      bad++;
      $display("FAIL rst_mid got=rdy%b req%b we%b s%b v%b e%b a%h wd%h rd%0d exp=rdy1 rest0", bus.op_ready, bus.mem_req, bus.mem_we, bus.MS2, bus.wb_valid, bus.mem_err, bus.mem_addr, bus.WD, bus.wb_rd);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.mem_req} !== 2'b00) begin
      bad++;
      $display("FAIL rst_after got=%b exp=00", {bus.wb_valid, bus.mem_req});
    end
  endtask
`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    put_op(OP_LOAD, 32'h300, 32'h0, 5'd6);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.mem_req, bus.mem_err} !== 2'b10) begin
        bad++;
        $display("FAIL to_wait%0d got=%b exp=10", i, {bus.mem_req, bus.mem_err});
      end
      tick();
    end
    total++;
    if ({bus.mem_req, bus.mem_err, bus.wb_valid, bus.op_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL to_abort got=%b exp=0101", {bus.mem_req, bus.mem_err, bus.wb_valid, bus.op_ready});
    end
    tick();
    total++;
    if ({bus.mem_err, bus.wb_valid} !== 2'b00) begin
      bad++;
      $display("FAIL to_pulse got=%b exp=00", {bus.mem_err, bus.wb_valid});
    end
    put_op(OP_LOAD, 32'h304, 32'h0, 5'd6);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
      end
      tick();
    end
    bus.mem_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.MS2, bus.mem_err, bus.WD} !== {3'b110, 32'hCAFE_0001}) begin
      bad++;
      $display("FAIL to_edge got=v%b s%b e%b wd%h exp=v1 s1 e0 wdcafe0001", bus.wb_valid, bus.MS2, bus.mem_err, bus.WD);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    put_op(OP_LOAD, 32'h300, 32'h0, 5'd6);
    tick();
    bus.op_valid = 1'b0;
    repeat (20) tick();
    total++;
    if ({bus.mem_req, bus.mem_err, bus.op_ready} !== 3'b100) begin
      bad++;
      $display("FAIL no_timeout got=%b exp=100", {bus.mem_req, bus.mem_err, bus.op_ready});
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ready = 1'b0;
    total++;
    if ({bus.wb_valid, bus.WD} !== {1'b1, 32'hCAFE_0001}) begin
      bad++;
      $display("FAIL late_ready got=v%b wd%h exp=v1 wdcafe0001", bus.wb_valid, bus.WD);
    end
    tick();
  endtask
`endif
  initial begin
    bus.op_valid = 1'b0;
    bus.op_kind = OP_NOP;
    bus.op_addr = '0;
    bus.op_wdata = '0;
    bus.op_rd = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_nop_rd0();
    test_rst_mid();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
